imem_arbiter: RTL and testbench

- Shares the single-port instruction memory (4096 x 32, byte write enables, 1-cycle registered read, read-before-write) between two requesters.
- Requesters: the instruction-fetch stage (read-only) and the program loader/debug port (read/write).
- Sits between the fetch unit / loader and the memory. Drives the memory EN/WE/adr/data_in and returns the read word to the requester whose access produced it.
- Handles priority, starvation protection, and response buffering when a requester back-pressures.

---
 rtl/rv32i_mem_pkg.sv | 32 +++
 rtl/imem_rsp_buf.sv | 122 ++++++++++++
 rtl/imem_arbiter.sv | 108 ++++++++++
 tb/tb_imem_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_mem_pkg.sv
// Shared types and constants for the instruction-memory access path.
package rv32i_mem_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LD = 1'b1
    } imem_owner_e;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_DATA = 2'd1,
        RSP_HOLD = 2'd2
    } imem_rsp_state_e;

    localparam int          IMEM_ADDR_W = 12;
    localparam int          IMEM_DATA_W = 32;
    localparam logic [3:0]  WE_READ     = 4'b0000;

    // Response-ready of whichever requester owns the outstanding access.
    function automatic logic owner_ready(input imem_owner_e owner,
                                         input logic if_ready,
                                         input logic ld_ready);
        logic rdy;
        if (owner == OWN_LD) begin
            rdy = ld_ready;
        end else begin
            rdy = if_ready;
        end
        return rdy;
    endfunction

endpackage

// File: rtl/imem_rsp_buf.sv
// One-entry response buffer: routes the memory read word to the access owner
// and parks it in a hold register while that owner back-pressures.
module imem_rsp_buf
    import rv32i_mem_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              grant,
    input  imem_owner_e       grant_owner,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              if_rsp_ready,
    input  logic              ld_rsp_ready,
    output logic              slot_free,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              ld_rsp_valid,
    output logic [DATA_W-1:0] ld_rsp_data
);

    imem_rsp_state_e   state_r;
    imem_rsp_state_e   state_next_s;
    imem_owner_e       owner_r;
    logic [DATA_W-1:0] hold_r;
    logic              rsp_ready_s;
    logic [DATA_W-1:0] rsp_data_s;

    assign rsp_ready_s = owner_ready(owner_r, if_rsp_ready, ld_rsp_ready);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= RSP_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Owner is latched at grant; the word is parked only when DATA is not consumed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_r <= OWN_IF;
            hold_r  <= {DATA_W{1'b0}};
        end else begin
            if (grant) begin
                owner_r <= grant_owner;
            end else begin
                owner_r <= owner_r;
            end
            if ((state_r == RSP_DATA) && !rsp_ready_s) begin
                hold_r <= mem_rdata;
            end else begin
                hold_r <= hold_r;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RSP_IDLE: begin
                if (grant) begin
                    state_next_s = RSP_DATA;
                end else begin
                    state_next_s = RSP_IDLE;
                end
            end
            RSP_DATA, RSP_HOLD: begin
                if (!rsp_ready_s) begin
                    state_next_s = RSP_HOLD;
                end else if (grant) begin
                    state_next_s = RSP_DATA;
                end else begin
                    state_next_s = RSP_IDLE;
                end
            end
            default: begin
                state_next_s = RSP_IDLE;
            end
        endcase
    end

    // Output decode: response routed to the owner only, zero elsewhere
    always_comb begin
        slot_free    = 1'b0;
        rsp_data_s   = {DATA_W{1'b0}};
        if_rsp_valid = 1'b0;
        ld_rsp_valid = 1'b0;
        if_rsp_data  = {DATA_W{1'b0}};
        ld_rsp_data  = {DATA_W{1'b0}};
        case (state_r)
            RSP_IDLE: begin
                slot_free = 1'b1;
            end
            RSP_DATA: begin
                slot_free  = rsp_ready_s;
                rsp_data_s = mem_rdata;
            end
            RSP_HOLD: begin
                slot_free  = rsp_ready_s;
                rsp_data_s = hold_r;
            end
            default: begin
                slot_free = 1'b0;
            end
        endcase
        if (state_r != RSP_IDLE) begin
            if (owner_r == OWN_LD) begin
                ld_rsp_valid = 1'b1;
                ld_rsp_data  = rsp_data_s;
            end else begin
                if_rsp_valid = 1'b1;
                if_rsp_data  = rsp_data_s;
            end
        end else begin
            if_rsp_valid = 1'b0;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction memory between fetch (read-only)
// and the loader (read/write), with fetch starvation protection.
module imem_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int DATA_W     = IMEM_DATA_W,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADDR_W-1:0] ld_req_addr,
    input  logic [3:0]        ld_req_we,
    input  logic [DATA_W-1:0] ld_req_wdata,
    output logic              ld_rsp_valid,
    input  logic              ld_rsp_ready,
    output logic [DATA_W-1:0] ld_rsp_data,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0]  starve_cnt_r;
    logic        starve_hit_s;
    logic        slot_free_s;
    logic        grant_if_s;
    logic        grant_ld_s;
    imem_owner_e grant_owner_s;

    assign starve_hit_s = (starve_cnt_r == STARVE_LIM);

    // Grant decision; nothing is granted while reset is held
    always_comb begin
        grant_if_s = 1'b0;
        grant_ld_s = 1'b0;
        if (rst_n && slot_free_s) begin
            if (ld_req_valid && !(if_req_valid && starve_hit_s)) begin
                grant_ld_s = 1'b1;
            end else if (if_req_valid) begin
                grant_if_s = 1'b1;
            end else begin
                grant_ld_s = 1'b0;
            end
        end else begin
            grant_if_s = 1'b0;
        end
    end

    // Memory drive and request handshakes follow the grant combinationally
    always_comb begin
        if_req_ready  = grant_if_s;
        ld_req_ready  = grant_ld_s;
        mem_en        = grant_if_s | grant_ld_s;
        mem_wdata     = ld_req_wdata;
        grant_owner_s = OWN_IF;
        if (grant_ld_s) begin
            mem_adr       = ld_req_addr;
            mem_we        = ld_req_we;
            grant_owner_s = OWN_LD;
        end else begin
            mem_adr       = if_req_addr;
            mem_we        = WE_READ;
        end
    end

    // Consecutive loader wins while fetch waits; saturates at the limit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_r <= 8'd0;
        end else if (!if_req_valid || grant_if_s) begin
            starve_cnt_r <= 8'd0;
        end else if (grant_ld_s && !starve_hit_s) begin
            starve_cnt_r <= starve_cnt_r + 8'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    imem_rsp_buf #(
        .DATA_W (DATA_W)
    ) u_rsp_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .grant        (grant_if_s | grant_ld_s),
        .grant_owner  (grant_owner_s),
        .mem_rdata    (mem_rdata),
        .if_rsp_ready (if_rsp_ready),
        .ld_rsp_ready (ld_rsp_ready),
        .slot_free    (slot_free_s),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .ld_rsp_valid (ld_rsp_valid),
        .ld_rsp_data  (ld_rsp_data)
    );

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: memory model, transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_imem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SM = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
    logic [AW-1:0] if_req_addr;
    logic [DW-1:0] if_rsp_data;
    logic          ld_req_valid, ld_req_ready, ld_rsp_valid, ld_rsp_ready;
    logic [AW-1:0] ld_req_addr;
    logic [3:0]    ld_req_we;
    logic [DW-1:0] ld_req_wdata, ld_rsp_data;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
        .ld_req_we(ld_req_we), .ld_req_wdata(ld_req_wdata),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_ready(ld_rsp_ready), .ld_rsp_data(ld_rsp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Single-port memory: registered read, read-before-write, byte enables
    logic [DW-1:0] mem [0:4095];
    logic [DW-1:0] mem_q;
    assign mem_rdata = mem_q;
    always @(posedge clk) begin
        if (mem_en) begin
            mem_q <= mem[mem_adr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_adr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory image plus queue of expected responses
    typedef struct packed { logic own_ld; logic [31:0] data; } exp_t;
    logic [DW-1:0] ref_mem [0:4095];
    exp_t          exp_q[$];
    int            starve = 0;
    bit            mon_en = 1'b0;
    bit            cont_en = 1'b0;
    int            run_len = 0;
    int            runs[$];
    logic [31:0]   if_caps[$];
    logic [31:0]   ld_caps[$];

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t front;
            bit has, fr_rdy, slot, gld, gif;
            has   = (exp_q.size() != 0);
            front = has ? exp_q[0] : '0;
            fr_rdy = has && (front.own_ld ? ld_rsp_ready : if_rsp_ready);
            slot  = !has || fr_rdy;
            gld   = rst_n && slot && ld_req_valid && !(if_req_valid && starve == SM);
            gif   = rst_n && slot && if_req_valid && !gld;
            check("ld_req_ready", 32'(ld_req_ready), 32'(gld));
            check("if_req_ready", 32'(if_req_ready), 32'(gif));
            check("mem_en", 32'(mem_en), 32'(gld | gif));
            if (gld | gif) begin
                check("mem_adr", 32'(mem_adr), gld ? 32'(ld_req_addr) : 32'(if_req_addr));
                check("mem_we", 32'(mem_we), gld ? 32'(ld_req_we) : 32'd0);
            end
            check("if_rsp_valid", 32'(if_rsp_valid), 32'(has && !front.own_ld));
            check("ld_rsp_valid", 32'(ld_rsp_valid), 32'(has && front.own_ld));
            if (has) check(front.own_ld ? "ld_rsp_data" : "if_rsp_data",
                           front.own_ld ? ld_rsp_data : if_rsp_data, front.data);
            if (fr_rdy) begin
                if (front.own_ld) ld_caps.push_back(ld_rsp_data);
                else              if_caps.push_back(if_rsp_data);
                void'(exp_q.pop_front());
            end
            if (gld) begin
                exp_q.push_back({1'b1, ref_mem[ld_req_addr]});
                for (int b = 0; b < 4; b++)
                    if (ld_req_we[b]) ref_mem[ld_req_addr][8*b +: 8] = ld_req_wdata[8*b +: 8];
            end
            if (gif) exp_q.push_back({1'b0, ref_mem[if_req_addr]});
            if (!rst_n || !if_req_valid || gif) starve = 0;
            else if (gld && starve < SM) starve++;
            if (!rst_n) exp_q.delete();
            if (cont_en) begin
                if (ld_req_ready) run_len++;
                else if (if_req_ready) begin runs.push_back(run_len); run_len = 0; end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: no handshake within budget", name);
    endtask

    task automatic ifetch(input logic [AW-1:0] a);
        bit g = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = a;
        for (int n = 0; n < 50 && !g; n++) begin
            @(negedge clk);
            g = if_req_ready;
            tick();
        end
        if (!g) timeout("ifetch");
        if_req_valid = 1'b0;
    endtask

    task automatic ld_op(input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] wd);
        bit g = 1'b0;
        ld_req_valid = 1'b1;
        ld_req_addr  = a;
        ld_req_we    = we;
        ld_req_wdata = wd;
        for (int n = 0; n < 50 && !g; n++) begin
            @(negedge clk);
            g = ld_req_ready;
            tick();
        end
        if (!g) timeout("ld_op");
        ld_req_valid = 1'b0;
    endtask

    initial begin
        bit g;
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        mem[5] = 32'h0000_0013;
        ref_mem[5] = 32'h0000_0013;
        mem_q = 32'd0;
        rst_n = 1'b0;
        if_req_valid = 1'b0; if_req_addr = '0; if_rsp_ready = 1'b1;
        ld_req_valid = 1'b0; ld_req_addr = '0; ld_req_we = 4'd0; ld_req_wdata = 32'd0;
        ld_rsp_ready = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        @(negedge clk);
        check("rst_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
        check("rst_ld_rsp_valid", 32'(ld_rsp_valid), 32'd0);
        check("rst_if_rsp_data", if_rsp_data, 32'd0);
        check("rst_ld_rsp_data", ld_rsp_data, 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fetch-only stream, one access per cycle, data one cycle later
        if_req_valid = 1'b1;
        for (int a = 0; a < 4; a++) begin
            if_req_addr = AW'(a);
            if (a == 3) if_req_valid = 1'b0;
            @(negedge clk);
            if (a < 3) check("stream_ready", 32'(if_req_ready), 32'd1);
            if (a > 0) check("stream_data", if_rsp_data, 32'h1000_0000 + 32'(a - 1));
            tick();
        end
        tick();
        check("stream_count", 32'(if_caps.size()), 32'd3);

        // Loader read-before-write, then partial byte write
        ld_op(12'd5, 4'hF, 32'hDEAD_BEEF);
        ld_op(12'd5, 4'h0, 32'h0);
        ld_op(12'd5, 4'h1, 32'h0000_00AA);
        ld_op(12'd5, 4'h0, 32'h0);
        tick(); tick();
        check("ld_count", 32'(ld_caps.size()), 32'd4);
        if (ld_caps.size() == 4) begin
            check("ld_prewrite", ld_caps[0], 32'h0000_0013);
            check("ld_readback", ld_caps[1], 32'hDEAD_BEEF);
            check("ld_partial_pre", ld_caps[2], 32'hDEAD_BEEF);
            check("ld_partial", ld_caps[3], 32'hDEAD_BEAA);
        end

        // Contention: both requesting continuously
        cont_en = 1'b1;
        ld_req_valid = 1'b1; ld_req_addr = 12'd20; ld_req_we = 4'd0;
        if_req_valid = 1'b1; if_req_addr = 12'd30;
        repeat (40) tick();
        ld_req_valid = 1'b0; if_req_valid = 1'b0;
        cont_en = 1'b0;
        tick(); tick();
        check("starve_runs", 32'(runs.size()), 32'd4);
        for (int i = 0; i < 3 && i < runs.size(); i++)
            check("starve_run_len", 32'(runs[i]), 32'd8);

        // Back-pressure: fetch of addr 3 held while loader waits
        if_rsp_ready = 1'b0;
        ifetch(12'd3);
        ld_req_valid = 1'b1; ld_req_addr = 12'd7; ld_req_we = 4'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(if_rsp_valid), 32'd1);
            check("hold_data", if_rsp_data, 32'h1000_0003);
            check("hold_ld_block", 32'(ld_req_ready), 32'd0);
            tick();
        end
        if_rsp_ready = 1'b1;
        @(negedge clk);
        check("drain_grant", 32'(ld_req_ready), 32'd1);
        tick();
        ld_req_valid = 1'b0;
        tick(); tick();
        check("drain_ld_data", ld_caps[ld_caps.size()-1], 32'h1000_0007);

        // Reset while a response is in DATA
        ifetch(12'd9);
        rst_n = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 12'd10;
        @(negedge clk);
        check("rst_mid_no_grant", 32'(if_req_ready), 32'd0);
        tick();
        @(negedge clk);
        check("rst_mid_if_valid", 32'(if_rsp_valid), 32'd0);
        check("rst_mid_mem_en", 32'(mem_en), 32'd0);
        tick();
        if_caps.delete();
        rst_n = 1'b1;
        g = 1'b0;
        for (int n = 0; n < 20 && !g; n++) begin
            @(negedge clk);
            g = if_req_ready;
            tick();
        end
        if (!g) timeout("post_reset_fetch");
        if_req_valid = 1'b0;
        tick(); tick();
        check("post_rst_count", 32'(if_caps.size()), 32'd1);
        if (if_caps.size() > 0) check("post_rst_data", if_caps[0], 32'h1000_000A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
